aes_dec_round_ctrl: RTL and testbench
=====================================

# aes_dec_round_ctrl

Iterative sequencer for AES-128 decryption. It accepts one 128-bit ciphertext block at a time and performs the initial AddRoundKey itself. It then runs the block through one shared inverse-round datapath nine times and once through the final-round datapath, then presents the plaintext on a valid/ready output. It sits between the IP's AXI-side block buffer and the round datapaths, and reads round keys from the expanded-key store by index.

## Interface
- ROUND_LAT, 3, cycles from stable state/key at inverse-round inputs to valid result.
- FINAL_LAT, 2, same, for final-round datapath.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ciphertext offered.
- in_ready  out  1  controller can accept a block.
- in_data  in  128  ciphertext.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer takes plaintext.
- out_data  out  128  plaintext.
- key_valid  in  1  key store holds a complete schedule.
- rk_addr  out  4  round-key index 0..10.
- rk_rdata  in  128  round key; synchronous read, valid one cycle after rk_addr.
- rd_state  out  128  state to both round datapaths.
- rd_key  out  128  key to both datapaths; equals rk_rdata.
- rd_result  in  128  inverse-round result.
- fd_result  in  128  final-round result.
- busy  out  1  high in any state except IDLE and DONE.
- round  out  4  current round counter, for debug.

## Operation
- States: IDLE, ARK_LOAD, ARK_APPLY, R_LOAD, R_WAIT, F_LOAD, F_WAIT, DONE.
- IDLE:
  - in_ready = key_valid.
  - On in_valid && in_ready: latch in_data into st, set round=10, go to ARK_LOAD.
- ARK_LOAD: rk_addr=10. Go to ARK_APPLY.
- ARK_APPLY:
  - st <= st ^ rk_rdata.
  - round <= 9, go to R_LOAD.
- R_LOAD:
  - rk_addr=round.
  - Clear wait counter wcnt.
  - Go to R_WAIT.
- R_WAIT:
  - rd_state=st, rd_key=rk_rdata, both held stable; rk_addr held at round.
  - wcnt increments each cycle.
  - On wcnt==ROUND_LAT-1: st <= rd_result.
    - If round==1: round <= 0, go to F_LOAD.
    - Otherwise round <= round-1, go to R_LOAD.
- F_LOAD: rk_addr=0. Go to F_WAIT.
- F_WAIT: same as R_WAIT, using FINAL_LAT; on the last cycle st <= fd_result, go to DONE.
- DONE:
  - out_valid=1, out_data=st.
  - On out_ready: go to IDLE.
  - The next block is accepted no earlier than the cycle after.
- in_ready is low in all states except IDLE; in_valid outside IDLE is ignored.
- Output is held stable until taken; out_ready low stalls indefinitely with no data loss.
- key_valid is sampled only at accept. Deassertion mid-block does not abort; the schedule must not be rewritten while busy.
- rk_addr is 0 whenever it is unused (IDLE, DONE).
- wcnt width: clog2(max(ROUND_LAT, FINAL_LAT)) bits, minimum 1.
- round never wraps below 0.

## Timing
- Reset values:
  - state=IDLE, st=0, round=0, wcnt=0, rk_addr=0.
  - out_valid=0, busy=0, rd_state=0.
  - in_ready follows key_valid.
- Latency: accept in cycle 0; out_valid first high in cycle 13+9·ROUND_LAT+FINAL_LAT. That is cycle 42 with the defaults.
- Throughput: one block per latency+1 cycles when out_ready is tied high.
- Reset mid-block aborts immediately. The block is lost, no output is produced, and the controller is in IDLE on the first clock after release.
- in_valid and out_ready are never acted on in the same cycle, because IDLE and DONE are disjoint.

## Structure
- Shared package aes_dec_pkg holds:
  - state enum;
  - NUM_ROUNDS=10;
  - RK_IDX_W=4;
  - BLOCK_W=128.
- One natural sub-module, aes_dec_wait_cnt: a loadable down-counter with a done pulse, reused for the R_WAIT and F_WAIT phases.
- Round datapaths and the key store are instantiated by the parent, not inside this block.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: in_data=69c4e0d86a7b0430d8cdb78070b4c55a, key schedule from 000102…0f, reference-model datapaths.
  - Required: out_data=00112233445566778899aabbccddeeff, with out_valid first high in cycle 42.
- rk_addr trace: 10, then 9..1 each held ROUND_LAT+1 cycles, then 0 held FINAL_LAT+1 cycles.
- Back-to-back blocks:
  - Stimulus: two vectors offered continuously with out_ready=1.
  - Required: second accepted in the cycle after the first out handshake; both outputs correct.
- Backpressure:
  - Stimulus: out_ready low for 20 cycles after out_valid.
  - Required: out_data stable, in_ready=0 throughout; release completes the handshake.
- Reset at cycle 15 of a block:
  - Required: all outputs return to reset values.
  - A new block afterwards decrypts correctly with full latency.
- Accept gating:
  - key_valid=0 with in_valid=1: in_ready=0 and no accept.
  - ROUND_LAT=4: latency is 51 cycles.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared types and constants for the iterative AES-128 decryption controller.
package aes_dec_pkg;
   localparam int NUM_ROUNDS = 10;
   localparam int RK_IDX_W   = 4;
   localparam int BLOCK_W    = 128;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARK_LOAD,
      S_ARK_APPLY,
      S_R_LOAD,
      S_R_WAIT,
      S_F_LOAD,
      S_F_WAIT,
      S_DONE
   } dec_state_e;
endpackage

// File: rtl/aes_dec_wait_cnt.sv
// Loadable down-counter. Pulses done on the last cycle of a datapath wait phase.
module aes_dec_wait_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (en && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   assign done = en && !load && (cnt_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/aes_dec_round_ctrl.sv
// AES-128 decryption sequencer: initial AddRoundKey, nine shared inverse rounds,
// one final round, then valid/ready output. Round datapaths and key store are external.
module aes_dec_round_ctrl
   import aes_dec_pkg::*;
#(
   parameter int ROUND_LAT = 3,
   parameter int FINAL_LAT = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [BLOCK_W-1:0]  in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BLOCK_W-1:0]  out_data,
   input  logic                key_valid,
   output logic [RK_IDX_W-1:0] rk_addr,
   input  logic [BLOCK_W-1:0]  rk_rdata,
   output logic [BLOCK_W-1:0]  rd_state,
   output logic [BLOCK_W-1:0]  rd_key,
   input  logic [BLOCK_W-1:0]  rd_result,
   input  logic [BLOCK_W-1:0]  fd_result,
   output logic                busy,
   output logic [RK_IDX_W-1:0] round
);
   localparam int MAX_LAT = (ROUND_LAT > FINAL_LAT) ? ROUND_LAT : FINAL_LAT;
   localparam int WCNT_W  = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [WCNT_W-1:0] R_LD = WCNT_W'(ROUND_LAT - 1);
   localparam logic [WCNT_W-1:0] F_LD = WCNT_W'(FINAL_LAT - 1);

   dec_state_e          state_q, state_d;
   logic [BLOCK_W-1:0]  st_q, st_d;
   logic [RK_IDX_W-1:0] round_q, round_d;
   logic                cnt_load, cnt_en, wait_done;
   logic [WCNT_W-1:0]   cnt_ld_val;

   aes_dec_wait_cnt #(.W(WCNT_W)) u_wait_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_ld_val),
      .en       (cnt_en),
      .done     (wait_done)
   );

   always_comb begin
      state_d    = state_q;
      st_d       = st_q;
      round_d    = round_q;
      cnt_load   = 1'b0;
      cnt_ld_val = R_LD;
      cnt_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && key_valid) begin
               st_d    = in_data;
               round_d = RK_IDX_W'(NUM_ROUNDS);
               state_d = S_ARK_LOAD;
            end
         end
         S_ARK_LOAD: state_d = S_ARK_APPLY;
         S_ARK_APPLY: begin
            st_d    = st_q ^ rk_rdata;
            round_d = RK_IDX_W'(NUM_ROUNDS - 1);
            state_d = S_R_LOAD;
         end
         S_R_LOAD: begin
            cnt_load   = 1'b1;
            cnt_ld_val = R_LD;
            state_d    = S_R_WAIT;
         end
         S_R_WAIT: begin
            cnt_en = 1'b1;
            if (wait_done) begin
               st_d = rd_result;
               if (round_q == RK_IDX_W'(1)) begin
                  round_d = '0;
                  state_d = S_F_LOAD;
               end else begin
                  round_d = round_q - 1'b1;
                  state_d = S_R_LOAD;
               end
            end
         end
         S_F_LOAD: begin
            cnt_load   = 1'b1;
            cnt_ld_val = F_LD;
            state_d    = S_F_WAIT;
         end
         S_F_WAIT: begin
            cnt_en = 1'b1;
            if (wait_done) begin
               st_d    = fd_result;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Between blocks the key index is parked at 0; inside a block it tracks round,
   // which already holds 10 during the initial AddRoundKey and 0 for the final round.
   assign rk_addr   = (state_q == S_IDLE || state_q == S_DONE) ? '0 : round_q;
   assign in_ready  = (state_q == S_IDLE) && key_valid;
   assign out_valid = (state_q == S_DONE);
   assign out_data  = st_q;
   assign rd_state  = st_q;
   assign rd_key    = rk_rdata;
   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign round     = round_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         st_q    <= '0;
         round_q <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         round_q <= round_d;
      end
   end
endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Directed bench: reference AES inverse-round datapaths with modelled latency around
// two controller instances (default latencies and ROUND_LAT=4).
module tb_aes_dec_round_ctrl;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

   logic         clk = 1'b0;
   logic         rst_n, key_valid, out_ready, in_valid, in_valid_b;
   logic [127:0] in_data;
   logic         in_ready, out_valid, busy, in_ready_b, out_valid_b, busy_b;
   logic [127:0] out_data, rd_state, rd_key, rk_rdata, rd_result, fd_result;
   logic [127:0] out_data_b, rd_state_b, rd_key_b, rk_rdata_b, rd_result_b, fd_result_b;
   logic [3:0]   rk_addr, round, rk_addr_b, round_b;

   logic [7:0]   sbox [256];
   logic [7:0]   isbox[256];
   logic [127:0] rk   [16];
   logic [127:0] rdp_a[2];
   logic [127:0] rdp_b[3];
   logic [127:0] fdp_a, fdp_b;

   int errors = 0;
   int checks = 0;
   int trace[64];
   int busy_low;

   always #5 clk = ~clk;

   aes_dec_round_ctrl #(.ROUND_LAT(3), .FINAL_LAT(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .key_valid(key_valid),
      .rk_addr(rk_addr), .rk_rdata(rk_rdata), .rd_state(rd_state), .rd_key(rd_key),
      .rd_result(rd_result), .fd_result(fd_result), .busy(busy), .round(round)
   );

   aes_dec_round_ctrl #(.ROUND_LAT(4), .FINAL_LAT(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(1'b1), .out_data(out_data_b), .key_valid(key_valid),
      .rk_addr(rk_addr_b), .rk_rdata(rk_rdata_b), .rd_state(rd_state_b), .rd_key(rd_key_b),
      .rd_result(rd_result_b), .fd_result(fd_result_b), .busy(busy_b), .round(round_b)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // InvShiftRows + InvSubBytes + AddRoundKey
   function automatic logic [127:0] inv_core(input logic [127:0] s, input logic [127:0] k);
      logic [127:0] t;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[127-8*(4*c+r) -: 8] = isbox[s[127-8*(4*((c-r+4)%4)+r) -: 8]];
      return t ^ k;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] t;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         t[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
         t[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
         t[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
         t[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
      end
      return t;
   endfunction

   function automatic logic [127:0] ref_dec(input logic [127:0] ct);
      logic [127:0] s;
      s = ct ^ rk[10];
      for (int r = 9; r >= 1; r--) s = inv_mix(inv_core(s, rk[r]));
      return inv_core(s, rk[0]);
   endfunction

   task automatic build_tables(input logic [127:0] key);
      logic [7:0]  inv, b, rcon;
      logic [31:0] w[44];
      logic [31:0] t;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sbox[x] = b ^ {b[6:0],b[7]} ^ {b[5:0],b[7:6]} ^ {b[4:0],b[7:5]} ^ {b[3:0],b[7:4]} ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rcon, 24'h0};
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++)
         rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
   endtask

   // Key store with one-cycle read, datapaths with LAT-1 register stages
   always @(posedge clk) begin
      rk_rdata   <= rk[rk_addr];
      rk_rdata_b <= rk[rk_addr_b];
      rdp_a[0]   <= inv_mix(inv_core(rd_state, rd_key));
      rdp_a[1]   <= rdp_a[0];
      fdp_a      <= inv_core(rd_state, rd_key);
      rdp_b[0]   <= inv_mix(inv_core(rd_state_b, rd_key_b));
      rdp_b[1]   <= rdp_b[0];
      rdp_b[2]   <= rdp_b[1];
      fdp_b      <= inv_core(rd_state_b, rd_key_b);
   end
   assign rd_result   = rdp_a[1];
   assign fd_result   = fdp_a;
   assign rd_result_b = rdp_b[2];
   assign fd_result_b = fdp_b;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called one cycle after accept; returns the cycle index of the first out_valid
   task automatic wait_done_a(output int n);
      n = 1;
      busy_low = 0;
      trace[1] = int'(rk_addr);
      while (!out_valid && n < 200) begin
         if (!busy) busy_low++;
         step();
         n++;
         if (n < 64) trace[n] = int'(rk_addr);
      end
   endtask

   initial begin
      int n, k, bad;
      int exp_tr[64];
      logic [127:0] ct2, ct3, exp2, exp3, hold;

      build_tables(FIPS_KEY);
      rst_n = 1'b0; in_valid = 1'b0; in_valid_b = 1'b0; in_data = '0;
      key_valid = 1'b1; out_ready = 1'b1;
      repeat (2) step();

      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_rk_addr", 128'(rk_addr), 128'd0);
      chk("rst_round", 128'(round), 128'd0);
      chk("rst_rd_state", rd_state, 128'd0);
      chk("rst_in_ready_kv1", 128'(in_ready), 128'd1);
      key_valid = 1'b0;
      #1;
      chk("rst_in_ready_kv0", 128'(in_ready), 128'd0);
      rst_n = 1'b1;
      step();

      // accept gated by key_valid
      in_valid = 1'b1; in_data = FIPS_CT;
      #1;
      chk("gate_in_ready", 128'(in_ready), 128'd0);
      repeat (3) step();
      chk("gate_no_accept_busy", 128'(busy), 128'd0);
      chk("gate_no_accept_round", 128'(round), 128'd0);

      // FIPS-197 C.1, key_valid dropped right after accept
      key_valid = 1'b1;
      #1;
      chk("blk1_in_ready", 128'(in_ready), 128'd1);
      step();
      in_valid = 1'b0; key_valid = 1'b0;
      chk("blk1_round_after_accept", 128'(round), 128'd10);
      wait_done_a(n);
      key_valid = 1'b1;
      #1;
      chk("blk1_latency", 128'(n), 128'd42);
      chk("blk1_plaintext", out_data, FIPS_PT);
      chk("blk1_in_ready_done", 128'(in_ready), 128'd0);
      chk("blk1_busy_gaps", 128'(busy_low), 128'd0);
      exp_tr[1] = 10; exp_tr[2] = 10; k = 3;
      for (int r = 9; r >= 1; r--)
         for (int j = 0; j < 4; j++) begin exp_tr[k] = r; k++; end
      for (int j = 0; j < 4; j++) begin exp_tr[k] = 0; k++; end
      bad = 0;
      for (int i = 1; i <= 42; i++) if (trace[i] != exp_tr[i]) bad++;
      chk("blk1_rk_addr_trace_bad", 128'(bad), 128'd0);
      step();
      chk("blk1_released_valid", 128'(out_valid), 128'd0);

      // back-to-back
      ct2 = 128'h0123456789abcdeffedcba9876543210;
      ct3 = 128'h3925841d02dc09fbdc118597196a0b32;
      exp2 = ref_dec(ct2);
      exp3 = ref_dec(ct3);
      in_valid = 1'b1; in_data = ct2;
      step();
      in_data = ct3;
      wait_done_a(n);
      chk("b2b_first_latency", 128'(n), 128'd42);
      chk("b2b_first_data", out_data, exp2);
      step();
      chk("b2b_second_ready", 128'(in_ready), 128'd1);
      step();
      in_valid = 1'b0;
      chk("b2b_second_round", 128'(round), 128'd10);
      wait_done_a(n);
      chk("b2b_second_latency", 128'(n), 128'd42);
      chk("b2b_second_data", out_data, exp3);
      step();

      // backpressure, with a competing block offered
      out_ready = 1'b0; in_valid = 1'b1; in_data = FIPS_CT;
      step();
      in_data = ct2;
      wait_done_a(n);
      chk("bp_latency", 128'(n), 128'd42);
      hold = out_data;
      bad = 0;
      repeat (20) begin
         step();
         if (out_valid !== 1'b1 || out_data !== hold || in_ready !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("bp_stall_bad", 128'(bad), 128'd0);
      chk("bp_data", hold, FIPS_PT);
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("bp_released_valid", 128'(out_valid), 128'd0);
      chk("bp_released_busy", 128'(busy), 128'd0);

      // reset at cycle 15 of a block
      in_valid = 1'b1; in_data = ct3;
      step();
      in_valid = 1'b0;
      repeat (14) step();
      chk("mid_busy_before_reset", 128'(busy), 128'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 128'(busy), 128'd0);
      chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
      chk("mid_rst_rk_addr", 128'(rk_addr), 128'd0);
      chk("mid_rst_round", 128'(round), 128'd0);
      chk("mid_rst_rd_state", rd_state, 128'd0);
      chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
      step();
      rst_n = 1'b1;
      step();
      chk("mid_idle_after_release", 128'(busy), 128'd0);
      in_valid = 1'b1; in_data = FIPS_CT;
      step();
      in_valid = 1'b0;
      wait_done_a(n);
      chk("post_rst_latency", 128'(n), 128'd42);
      chk("post_rst_data", out_data, FIPS_PT);
      step();

      // ROUND_LAT=4 instance
      in_valid_b = 1'b1; in_data = FIPS_CT;
      #1;
      chk("rl4_in_ready", 128'(in_ready_b), 128'd1);
      step();
      in_valid_b = 1'b0;
      n = 1;
      while (!out_valid_b && n < 200) begin step(); n++; end
      chk("rl4_latency", 128'(n), 128'd51);
      chk("rl4_data", out_data_b, FIPS_PT);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
